// File: rtl/rr_grant_decoder_arbiter.sv
// Four-way round-robin arbiter with an active-low one-hot grant bus, encoded grant ID,
// per-grant hold limit and a mandatory dead cycle between consecutive grants.
module rr_grant_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt_n,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       forced
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // The hold counter stores (cycles held - 1), so MAX_HOLD = 2^CNT_W still fits.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_last_id;
  logic [1:0]       r_gnt_id;
  logic [3:0]       r_gnt_n;
  logic             r_valid;
  logic             r_forced;
  logic [CNT_W-1:0] r_hold;

  logic [3:0]       w_req_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_win_id;
  logic             w_arb_ok;
  logic             w_grant_start;
  logic             w_release;
  logic             w_release_forced;

  // Rotate requests so bit 0 is the requester just after the last grantee.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign w_req_rot[gi] = req[2'(r_last_id + 2'(gi + 1))];
    end
  endgenerate

  always_comb begin
    w_off = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (w_req_rot[j]) w_off = 2'(j);
    end
  end

  assign w_win_id = r_last_id + 2'd1 + w_off;
  assign w_arb_ok = en && (|req);

  always_comb begin
    w_state_next     = r_state;
    w_grant_start    = 1'b0;
    w_release        = 1'b0;
    w_release_forced = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_ok) begin
          w_state_next  = S_GRANT;
          w_grant_start = 1'b1;
        end
      end
      S_GRANT: begin
        if (!req[r_gnt_id] || !en) begin
          w_state_next = S_RELEASE;
          w_release    = 1'b1;
        end else if (r_hold == HOLD_LAST) begin
          w_state_next     = S_RELEASE;
          w_release        = 1'b1;
          w_release_forced = 1'b1;
        end
      end
      S_RELEASE: begin
        if (w_arb_ok) begin
          w_state_next  = S_GRANT;
          w_grant_start = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_last_id <= 2'd3;
      r_gnt_id  <= 2'd0;
      r_gnt_n   <= 4'b1111;
      r_valid   <= 1'b0;
      r_forced  <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_start) begin
        r_gnt_id  <= w_win_id;
        r_last_id <= w_win_id;
        r_gnt_n   <= ~(4'b0001 << w_win_id);
        r_valid   <= 1'b1;
        r_forced  <= 1'b0;
        r_hold    <= '0;
      end else if (w_release) begin
        r_gnt_n  <= 4'b1111;
        r_valid  <= 1'b0;
        r_forced <= w_release_forced;
      end else if (r_state == S_GRANT) begin
        r_hold <= r_hold + 1'b1;
      end else begin
        r_forced <= 1'b0;
      end
    end
  end

  assign gnt_n     = r_gnt_n;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_valid;
  assign forced    = r_forced;

endmodule

// File: tb/tb_rr_grant_decoder_arbiter.sv
// Vector table plus scoreboard bench for rr_grant_decoder_arbiter (MAX_HOLD=8),
// with a hand-written asynchronous reset-mid-grant sequence at the end.
module tb_rr_grant_decoder_arbiter;

  logic       clk;
  logic       resetn;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt_n;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       forced;

  int total = 0;
  int bad   = 0;

  rr_grant_decoder_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .forced    (forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt_n;
    logic [1:0] id;
    logic       valid;
    logic       forced;
  } vec_t;

  typedef struct {
    logic [3:0] gnt_n;
    logic [1:0] id;
    logic       valid;
    logic       forced;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic logic [3:0] dec(input int g);
    case (g)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      3:       return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic add(input logic r, input logic e, input logic [3:0] q, input logic [3:0] g,
                     input logic [1:0] id, input logic v, input logic f);
    vec_t x;
    x.rst = r; x.en = e; x.req = q; x.gnt_n = g; x.id = id; x.valid = v; x.forced = f;
    tbl.push_back(x);
  endtask

  task automatic check_out(input string name);
    exp_t x;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, nothing to compare", name);
      return;
    end
    x = exp_q.pop_front();
    total++;
    if (gnt_n !== x.gnt_n || gnt_id !== x.id || gnt_valid !== x.valid || forced !== x.forced) begin
      bad++;
      $display("FAIL %s: got gnt_n=%b id=%b valid=%b forced=%b, want gnt_n=%b id=%b valid=%b forced=%b",
               name, gnt_n, gnt_id, gnt_valid, forced, x.gnt_n, x.id, x.valid, x.forced);
    end else begin
      $display("ok %s: gnt_n=%b id=%b valid=%b forced=%b", name, gnt_n, gnt_id, gnt_valid, forced);
    end
  endtask

  task automatic drive_expect(input logic r, input logic e, input logic [3:0] q,
                              input logic [3:0] g, input logic [1:0] id, input logic v, input logic f);
    exp_t x;
    @(negedge clk);
    resetn = ~r;
    en     = e;
    req    = q;
    x.gnt_n = g; x.id = id; x.valid = v; x.forced = f;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b0;
    req    = 4'b0000;

    // Idle after reset release
    for (int i = 0; i < 10; i++) add(0, 1, 4'b0000, 4'b1111, 2'd0, 0, 0);
    // Single request to 2, dropped after four granted cycles
    for (int i = 0; i < 4; i++) add(0, 1, 4'b0100, 4'b1011, 2'd2, 1, 0);
    add(0, 1, 4'b0000, 4'b1111, 2'd2, 0, 0);
    add(0, 1, 4'b0000, 4'b1111, 2'd2, 0, 0);
    add(0, 1, 4'b0000, 4'b1111, 2'd2, 0, 0);
    // Fresh reset, then all four requesting: 8-cycle grants with forced gaps
    add(1, 1, 4'b1111, 4'b1111, 2'd0, 0, 0);
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 8; i++) add(0, 1, 4'b1111, dec(g), 2'(g), 1, 0);
      add(0, 1, 4'b1111, 4'b1111, 2'(g), 0, 1);
    end
    for (int i = 0; i < 8; i++) add(0, 1, 4'b1111, dec(0), 2'd0, 1, 0);
    add(0, 1, 4'b1111, 4'b1111, 2'd0, 0, 1);
    add(0, 1, 4'b1111, dec(1), 2'd1, 1, 0);
    // Grantee 1 drops with 0 and 3 pending: 3 is next, then 0
    add(0, 1, 4'b1001, 4'b1111, 2'd1, 0, 0);
    add(0, 1, 4'b1001, dec(3), 2'd3, 1, 0);
    add(0, 1, 4'b0001, 4'b1111, 2'd3, 0, 0);
    add(0, 1, 4'b0001, dec(0), 2'd0, 1, 0);
    // Drop and reassert in RELEASE: loses to a pending peer, wins when alone
    add(0, 1, 4'b0000, 4'b1111, 2'd0, 0, 0);
    add(0, 1, 4'b0011, dec(1), 2'd1, 1, 0);
    add(0, 1, 4'b0000, 4'b1111, 2'd1, 0, 0);
    add(0, 1, 4'b0010, dec(1), 2'd1, 1, 0);
    add(0, 1, 4'b0000, 4'b1111, 2'd1, 0, 0);
    add(0, 1, 4'b0000, 4'b1111, 2'd1, 0, 0);
    // en falls during grant to 2: RELEASE unforced, IDLE while blocked, then 3
    add(0, 1, 4'b0100, dec(2), 2'd2, 1, 0);
    add(0, 0, 4'b1111, 4'b1111, 2'd2, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 4'b1111, 4'b1111, 2'd2, 0, 0);
    add(0, 1, 4'b1111, dec(3), 2'd3, 1, 0);
    add(0, 1, 4'b1111, dec(3), 2'd3, 1, 0);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      drive_expect(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].gnt_n, tbl[i].id,
                   tbl[i].valid, tbl[i].forced);
      check_out($sformatf("row%0d", i));
    end

    // Asynchronous reset while granted to 3: outputs clear before any clock edge
    @(negedge clk);
    resetn = 1'b0;
    #1;
    begin
      exp_t x;
      x.gnt_n = 4'b1111; x.id = 2'd0; x.valid = 1'b0; x.forced = 1'b0;
      exp_q.push_back(x);
    end
    check_out("async_reset");

    drive_expect(0, 1, 4'b1111, dec(0), 2'd0, 1, 0);
    check_out("post_reset_grant0");
    drive_expect(0, 1, 4'b1111, dec(0), 2'd0, 1, 0);
    check_out("post_reset_hold0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
